// File: rtl/stopwatch_timer_core.sv
// Stopwatch / countdown timer core: H:M:S counting, preset register with range
// checking, auto-reloading timer mode, blinking alarm and a lap capture FIFO.
module stopwatch_timer_core #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned MAX_HOURS     = 24,
  parameter int unsigned LAP_DEPTH     = 4,
  parameter int unsigned BLINK_CYCLES  = 20_000_000,
  parameter int unsigned HW            = (MAX_HOURS > 1) ? $clog2(MAX_HOURS) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       clear,
  input  logic                       lap,
  input  logic                       mode_toggle,
  input  logic                       auto_reload,
  input  logic                       preset_load,
  input  logic [HW-1:0]              preset_h,
  input  logic [5:0]                 preset_m,
  input  logic [5:0]                 preset_s,
  input  logic                       lap_rd,
  output logic [HW-1:0]              hours,
  output logic [5:0]                 minutes,
  output logic [5:0]                 seconds,
  output logic [1:0]                 state,
  output logic                       mode,
  output logic                       time_up,
  output logic                       alarm,
  output logic                       wrap,
  output logic                       preset_err,
  output logic [HW-1:0]              lap_h,
  output logic [5:0]                 lap_m,
  output logic [5:0]                 lap_s,
  output logic [$clog2(LAP_DEPTH):0] lap_count,
  output logic                       lap_ovf
);

  localparam int unsigned PW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_UP    = 2'b11
  } state_e;

  typedef struct packed {
    logic [HW-1:0] h;
    logic [5:0]    m;
    logic [5:0]    s;
  } hms_t;

  localparam hms_t ZERO_T   = hms_t'({HW'(0), 6'd0, 6'd0});
  localparam hms_t ONE_T    = hms_t'({HW'(0), 6'd0, 6'd1});
  localparam hms_t MAX_T    = hms_t'({HW'(MAX_HOURS - 1), 6'd59, 6'd59});
  localparam hms_t PRESET_R = hms_t'({HW'(0), 6'd0, 6'd59});

  function automatic hms_t hms_inc(input hms_t t);
    hms_t r;
    r = t;
    if (t.s != 6'd59) begin
      r.s = t.s + 6'd1;
    end else begin
      r.s = 6'd0;
      if (t.m != 6'd59) begin
        r.m = t.m + 6'd1;
      end else begin
        r.m = 6'd0;
        r.h = (32'(t.h) >= MAX_HOURS - 1) ? HW'(0) : t.h + HW'(1);
      end
    end
    return r;
  endfunction

  function automatic hms_t hms_dec(input hms_t t);
    hms_t r;
    r = t;
    if (t.s != 6'd0) begin
      r.s = t.s - 6'd1;
    end else begin
      r.s = 6'd59;
      if (t.m != 6'd0) begin
        r.m = t.m - 6'd1;
      end else begin
        r.m = 6'd59;
        r.h = t.h - HW'(1);
      end
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  hms_t          time_q, time_d;
  hms_t          preset_q, preset_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          alarm_q, alarm_d;
  logic          time_up_q, time_up_d;
  logic          wrap_q, wrap_d;
  logic          perr_q, perr_d;
  hms_t          mem_q [LAP_DEPTH];
  hms_t          mem_d [LAP_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  hms_t          head_q, head_d;

  hms_t preset_in;
  logic preset_ok;
  logic tick;
  logic push;
  logic pop;

  assign preset_in = hms_t'({preset_h, preset_m, preset_s});
  assign preset_ok = (preset_m <= 6'd59) && (preset_s <= 6'd59) && (32'(preset_h) < MAX_HOURS);
  assign tick      = (state_q == S_RUN) && (presc_q == TW'(TICKS_PER_SEC - 1));

  // Command decode and time update; clear outranks everything else.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    time_d    = time_q;
    preset_d  = preset_q;
    time_up_d = 1'b0;
    wrap_d    = 1'b0;
    perr_d    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      time_d  = mode_q ? preset_q : ZERO_T;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) state_d = S_PAUSE;
          if (tick) begin
            if (!mode_q) begin
              time_d = hms_inc(time_q);
              wrap_d = (time_q == MAX_T);
            end else if (time_q == ONE_T || time_q == ZERO_T) begin
              time_up_d = 1'b1;
              if (auto_reload && preset_q != ZERO_T) begin
                time_d = preset_q;
              end else begin
                time_d  = ZERO_T;
                state_d = S_UP;
              end
            end else begin
              time_d = hms_dec(time_q);
            end
          end
        end
        default: begin
          if (preset_load) begin
            if (preset_ok) begin
              preset_d = preset_in;
              if (state_q == S_IDLE && mode_q) time_d = preset_in;
            end else begin
              perr_d = 1'b1;
            end
          end else if (mode_toggle && state_q == S_IDLE) begin
            mode_d = !mode_q;
            time_d = mode_q ? ZERO_T : preset_q;
          end else if (start) begin
            case (state_q)
              S_IDLE:  if (!(mode_q && time_q == ZERO_T)) state_d = S_RUN;
              S_PAUSE: state_d = S_RUN;
              S_UP: begin
                state_d = S_IDLE;
                time_d  = preset_q;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Prescaler restarts on every entry to RUNNING; alarm starts high on entry to TIME_UP.
  always_comb begin
    presc_d = (state_q == S_RUN && state_d == S_RUN && !tick) ? presc_q + TW'(1) : TW'(0);
    blink_d = BW'(0);
    alarm_d = 1'b0;
    if (state_d == S_UP) begin
      if (state_q != S_UP) begin
        alarm_d = 1'b1;
      end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
        alarm_d = !alarm_q;
      end else begin
        blink_d = blink_q + BW'(1);
        alarm_d = alarm_q;
      end
    end
  end

  assign push = lap && !mode_q && (state_q == S_RUN || state_q == S_PAUSE) && !clear;
  assign pop  = lap_rd && (cnt_q != CW'(0)) && !clear;

  // Lap FIFO: pop before push, a push into a full FIFO drops the oldest entry.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clear) begin
      rd_ptr_d = PW'(0);
      wr_ptr_d = PW'(0);
      cnt_d    = CW'(0);
      ovf_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_d + PW'(1);
        cnt_d    = cnt_d - CW'(1);
      end
      if (push) begin
        mem_d[wr_ptr_q] = time_q;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        if (cnt_d == CW'(LAP_DEPTH)) begin
          rd_ptr_d = rd_ptr_d + PW'(1);
          ovf_d    = 1'b1;
        end else begin
          cnt_d = cnt_d + CW'(1);
        end
      end
    end
    head_d = (cnt_d == CW'(0)) ? ZERO_T : mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      time_q    <= ZERO_T;
      preset_q  <= PRESET_R;
      presc_q   <= TW'(0);
      blink_q   <= BW'(0);
      alarm_q   <= 1'b0;
      time_up_q <= 1'b0;
      wrap_q    <= 1'b0;
      perr_q    <= 1'b0;
      for (int unsigned i = 0; i < LAP_DEPTH; i++) mem_q[i] <= ZERO_T;
      rd_ptr_q  <= PW'(0);
      wr_ptr_q  <= PW'(0);
      cnt_q     <= CW'(0);
      ovf_q     <= 1'b0;
      head_q    <= ZERO_T;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      time_q    <= time_d;
      preset_q  <= preset_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      alarm_q   <= alarm_d;
      time_up_q <= time_up_d;
      wrap_q    <= wrap_d;
      perr_q    <= perr_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      head_q    <= head_d;
    end
  end

  assign hours      = time_q.h;
  assign minutes    = time_q.m;
  assign seconds    = time_q.s;
  assign state      = state_q;
  assign mode       = mode_q;
  assign time_up    = time_up_q;
  assign alarm      = alarm_q;
  assign wrap       = wrap_q;
  assign preset_err = perr_q;
  assign lap_h      = head_q.h;
  assign lap_m      = head_q.m;
  assign lap_s      = head_q.s;
  assign lap_count  = cnt_q;
  assign lap_ovf    = ovf_q;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Self-checking bench for stopwatch_timer_core: a vector table for the stopwatch and
// lap FIFO path, plus hand-written sequences for presets, timer expiry, wrap and reset.
module tb_stopwatch_timer_core;

  localparam int unsigned HW = 1;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_START = 6'b100000;
  localparam logic [5:0] C_PAUSE = 6'b010000;
  localparam logic [5:0] C_CLEAR = 6'b001000;
  localparam logic [5:0] C_LAP   = 6'b000100;
  localparam logic [5:0] C_RD    = 6'b000010;
  localparam logic [5:0] C_MT    = 6'b000001;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, pause, clear, lap, mode_toggle, auto_reload, preset_load, lap_rd;
  logic [HW-1:0] preset_h;
  logic [5:0]    preset_m, preset_s;
  logic [HW-1:0] hours, lap_h;
  logic [5:0]    minutes, seconds, lap_m, lap_s;
  logic [1:0]    state;
  logic          mode, time_up, alarm, wrap, preset_err, lap_ovf;
  logic [2:0]    lap_count;

  stopwatch_timer_core #(
    .TICKS_PER_SEC(4),
    .MAX_HOURS    (2),
    .LAP_DEPTH    (4),
    .BLINK_CYCLES (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .lap        (lap),
    .mode_toggle(mode_toggle),
    .auto_reload(auto_reload),
    .preset_load(preset_load),
    .preset_h   (preset_h),
    .preset_m   (preset_m),
    .preset_s   (preset_s),
    .lap_rd     (lap_rd),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .state      (state),
    .mode       (mode),
    .time_up    (time_up),
    .alarm      (alarm),
    .wrap       (wrap),
    .preset_err (preset_err),
    .lap_h      (lap_h),
    .lap_m      (lap_m),
    .lap_s      (lap_s),
    .lap_count  (lap_count),
    .lap_ovf    (lap_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] cmd;
    int         idle;
    int         st;
    int         t;
    int         cnt;
    int         ovf;
    int         hd;
  } vec_t;

  vec_t vecs [17];
  vec_t sbq [$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] c);
    {start, pause, clear, lap, lap_rd, mode_toggle} = c;
    step();
    {start, pause, clear, lap, lap_rd, mode_toggle} = 6'b0;
  endtask

  task automatic pload(input int h, input int m, input int s);
    preset_h    = HW'(h);
    preset_m    = 6'(m);
    preset_s    = 6'(s);
    preset_load = 1'b1;
    step();
    preset_load = 1'b0;
  endtask

  function automatic int tsec();
    return int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds);
  endfunction

  function automatic int lsec();
    return int'(lap_h) * 3600 + int'(lap_m) * 60 + int'(lap_s);
  endfunction

  function automatic vec_t mk(input logic [5:0] c, input int idle, input int st, input int t,
                              input int cnt, input int ovf, input int hd);
    vec_t v;
    v.cmd = c; v.idle = idle; v.st = st; v.t = t; v.cnt = cnt; v.ovf = ovf; v.hd = hd;
    return v;
  endfunction

  initial begin
    vec_t e;
    int   tu_cnt, zero_cnt, bad_st, wrap_cnt;

    // Stopwatch, TICKS_PER_SEC=4: seconds are counted in units of 4 clock edges.
    vecs[0]  = mk(C_NONE,        0,   0,  0, 0, 0,  0);
    vecs[1]  = mk(C_LAP,         0,   0,  0, 0, 0,  0);
    vecs[2]  = mk(C_START,       238, 1, 59, 0, 0,  0);
    vecs[3]  = mk(C_NONE,        1,   1, 60, 0, 0,  0);
    vecs[4]  = mk(C_PAUSE,       19,  2, 60, 0, 0,  0);
    vecs[5]  = mk(C_START,       2,   1, 60, 0, 0,  0);
    vecs[6]  = mk(C_NONE,        0,   1, 60, 0, 0,  0);
    vecs[7]  = mk(C_NONE,        0,   1, 61, 0, 0,  0);
    vecs[8]  = mk(C_LAP,         3,   1, 62, 1, 0, 61);
    vecs[9]  = mk(C_LAP,         3,   1, 63, 2, 0, 61);
    vecs[10] = mk(C_LAP,         3,   1, 64, 3, 0, 61);
    vecs[11] = mk(C_LAP,         3,   1, 65, 4, 0, 61);
    vecs[12] = mk(C_LAP,         3,   1, 66, 4, 1, 62);
    vecs[13] = mk(C_LAP,         3,   1, 67, 4, 1, 63);
    vecs[14] = mk(C_LAP | C_RD,  0,   1, 67, 4, 1, 64);
    vecs[15] = mk(C_RD,          0,   1, 67, 3, 1, 65);
    vecs[16] = mk(C_CLEAR,       0,   0,  0, 0, 0,  0);

    {start, pause, clear, lap, lap_rd, mode_toggle} = 6'b0;
    auto_reload = 1'b0;
    preset_load = 1'b0;
    preset_h = '0; preset_m = '0; preset_s = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("reset.alarm", int'(alarm), 0);
    chk("reset.preset_err", int'(preset_err), 0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].cmd);
      sbq.push_back(vecs[i]);
      repeat (vecs[i].idle) step();
      e = sbq.pop_front();
      chk($sformatf("v%0d.state", i), int'(state), e.st);
      chk($sformatf("v%0d.mode", i), int'(mode), 0);
      chk($sformatf("v%0d.time", i), tsec(), e.t);
      chk($sformatf("v%0d.lap_count", i), int'(lap_count), e.cnt);
      chk($sformatf("v%0d.lap_ovf", i), int'(lap_ovf), e.ovf);
      chk($sformatf("v%0d.lap_head", i), lsec(), e.hd);
    end

    // Preset range checking, then timer mode picks up the unchanged preset.
    pload(0, 60, 0);
    chk("perr.m60", int'(preset_err), 1);
    step();
    chk("perr.pulse_end", int'(preset_err), 0);
    pload(0, 0, 60);
    chk("perr.s60", int'(preset_err), 1);
    drive(C_MT);
    chk("timer.mode", int'(mode), 1);
    chk("timer.preset_kept", tsec(), 59);
    pload(0, 0, 2);
    chk("timer.load_copy", tsec(), 2);
    chk("timer.load_ok", int'(preset_err), 0);

    // Timer expiry without reload; preset_load while running must be ignored.
    drive(C_START);
    chk("timer.run", int'(state), 1);
    pload(0, 0, 5);
    chk("timer.run_load_noerr", int'(preset_err), 0);
    repeat (6) step();
    chk("timer.t_before", tsec(), 1);
    chk("timer.tu_before", int'(time_up), 0);
    step();
    chk("timer.expire_t", tsec(), 0);
    chk("timer.expire_tu", int'(time_up), 1);
    chk("timer.expire_st", int'(state), 3);
    chk("timer.alarm_entry", int'(alarm), 1);
    step();
    chk("timer.tu_single", int'(time_up), 0);
    chk("timer.alarm_hold", int'(alarm), 1);
    repeat (2) step();
    chk("timer.alarm_low", int'(alarm), 0);
    repeat (3) step();
    chk("timer.alarm_high2", int'(alarm), 1);
    drive(C_START);
    chk("timer.ack_st", int'(state), 0);
    chk("timer.ack_t", tsec(), 2);
    chk("timer.ack_alarm", int'(alarm), 0);

    // Auto-reload with a one-second preset.
    pload(0, 0, 1);
    chk("auto.load", tsec(), 1);
    auto_reload = 1'b1;
    drive(C_START);
    tu_cnt = 0; zero_cnt = 0; bad_st = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (time_up) tu_cnt++;
      if (tsec() == 0) zero_cnt++;
      if (state != 2'b01) bad_st++;
    end
    chk("auto.tu_count", tu_cnt, 5);
    chk("auto.zero_seen", zero_cnt, 0);
    chk("auto.not_running", bad_st, 0);
    drive(C_CLEAR);
    chk("auto.clear_st", int'(state), 0);
    chk("auto.clear_t", tsec(), 1);
    auto_reload = 1'b0;

    // A zero timer refuses to start.
    pload(0, 0, 0);
    drive(C_START);
    chk("timer.zero_start", int'(state), 0);

    // Stopwatch wrap at 1:59:59 with MAX_HOURS=2.
    drive(C_MT);
    chk("wrap.mode", int'(mode), 0);
    chk("wrap.t0", tsec(), 0);
    drive(C_START);
    wrap_cnt = 0;
    for (int i = 0; i < 28799; i++) begin
      step();
      if (wrap) wrap_cnt++;
    end
    chk("wrap.t_max", tsec(), 7199);
    chk("wrap.early", wrap_cnt, 0);
    step();
    chk("wrap.t_zero", tsec(), 0);
    chk("wrap.pulse", int'(wrap), 1);
    chk("wrap.st", int'(state), 1);
    step();
    chk("wrap.pulse_end", int'(wrap), 0);

    // Reset in the middle of a run.
    drive(C_LAP);
    chk("rst.lap_pre", int'(lap_count), 1);
    reset_n = 1'b0;
    step();
    chk("rst.state", int'(state), 0);
    chk("rst.mode", int'(mode), 0);
    chk("rst.time", tsec(), 0);
    chk("rst.lap_count", int'(lap_count), 0);
    chk("rst.lap_ovf", int'(lap_ovf), 0);
    chk("rst.alarm", int'(alarm), 0);
    chk("rst.wrap", int'(wrap), 0);
    reset_n = 1'b1;
    drive(C_MT);
    chk("rst.preset", tsec(), 59);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
